picorv32_mem_ctrl: RTL and testbench

Bus controller between the PicoRV32 native memory port (valid/ready handshake) and the single-cycle-latency BRAM memory block (picorv32_mem), which has no handshake. It sequences BRAM accesses with a fixed wait state and decodes a small MMIO window. The window holds a TX FIFO and an RX holding register for the NoC link, plus a status register. Unmapped accesses complete with a bus-error pulse so the core never hangs.

---
 rtl/picorv32_mem_ctrl_if.sv | 21 ++
 rtl/picorv32_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_picorv32_mem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_mem_ctrl_if.sv
// picorv32_mem_ctrl_if - PicoRV32 native memory port (valid/ready handshake).
//   master : the core side, drives the request and samples the response.
//   slave  : the controller side, samples the request and drives the response.
//   cpu_mem_valid/instr/addr/wdata/wstrb : request (wstrb==0 means read)
//   cpu_mem_ready/rdata                  : one-cycle completion pulse and read data
interface picorv32_mem_ctrl_if;
   logic        cpu_mem_valid;
   logic        cpu_mem_instr;
   logic [31:0] cpu_mem_addr;
   logic [31:0] cpu_mem_wdata;
   logic [3:0]  cpu_mem_wstrb;
   logic        cpu_mem_ready;
   logic [31:0] cpu_mem_rdata;

   modport master (output cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata,
                          cpu_mem_wstrb,
                   input  cpu_mem_ready, cpu_mem_rdata);
   modport slave  (input  cpu_mem_valid, cpu_mem_instr, cpu_mem_addr, cpu_mem_wdata,
                          cpu_mem_wstrb,
                   output cpu_mem_ready, cpu_mem_rdata);
endinterface

// File: rtl/picorv32_mem_ctrl.sv
// picorv32_mem_ctrl - bus controller between the PicoRV32 memory port and a
// single-cycle-latency BRAM, plus a small MMIO window for the NoC link.
//   clk, rst        : clock, synchronous active-high reset
//   cpu             : core memory port (slave side)
//   mem_addr/wdata/wstrb, mem_rdata : BRAM port (rdata one clk after address)
//   link_tx_*       : TX FIFO head towards the link (valid/ready)
//   link_rx_*       : incoming link word into the RX holding register
//   bus_err         : one-cycle pulse with the ready of an unmapped access
// Memory accesses answer two cycles after valid, MMIO/unmapped after one.
module picorv32_mem_ctrl #(
   parameter logic [31:0] MEM_TOP   = 32'h0001_0000,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
   parameter int          TX_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   picorv32_mem_ctrl_if.slave  cpu,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [3:0]          mem_wstrb,
   input  logic [31:0]         mem_rdata,
   output logic [31:0]         link_tx_data,
   output logic                link_tx_valid,
   input  logic                link_tx_ready,
   input  logic [31:0]         link_rx_data,
   input  logic                link_rx_valid,
   output logic                link_rx_ready,
   output logic                bus_err
);
   localparam int AW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {IDLE, MWAIT, RESP} state_t;
   state_t state, state_nxt;

   logic [31:0] rdata_q, maddr_q, mwdata_q, mmio_rd, status;
   logic        err_q;
   logic        is_mem, is_mmio, is_rd, idle_req, go_mem, go_resp;
   logic        tx_push, tx_pop, tx_full, tx_empty, rx_pop, rx_valid;
   logic [1:0]  off;
   logic [AW:0] wr_ptr, rd_ptr, tx_occ;
   logic [31:0] tx_mem [TX_DEPTH];
   logic [31:0] rx_data;

   // the fetch flag carries no meaning for this controller
   logic unused_instr;
   assign unused_instr = cpu.cpu_mem_instr;

   // ---------------- decode and request qualification ----------------
   always_comb begin
      is_mem   = cpu.cpu_mem_addr < MEM_TOP;
      is_mmio  = cpu.cpu_mem_addr[31:4] == MMIO_BASE[31:4];
      off      = cpu.cpu_mem_addr[3:2];
      is_rd    = cpu.cpu_mem_wstrb == 4'h0;
      // rst gates the request so outputs sit at reset values while it is held
      idle_req = (state == IDLE) && cpu.cpu_mem_valid && !rst;
      go_mem   = idle_req && is_mem;
      tx_push  = idle_req && is_mmio && off == 2'd0 && !is_rd && !tx_full;
      // a TX write into a full FIFO stays in IDLE and retries every cycle
      go_resp  = idle_req && !is_mem &&
                 !(is_mmio && off == 2'd0 && !is_rd && tx_full);
      rx_pop   = idle_req && is_mmio && off == 2'd1 && is_rd && rx_valid;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_mem) state_nxt = MWAIT;
                  else if (go_resp) state_nxt = RESP;
         MWAIT:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      cpu.cpu_mem_ready = state == RESP;
      cpu.cpu_mem_rdata = (state == RESP) ? rdata_q : 32'h0;
      bus_err           = (state == RESP) && err_q;
      // BRAM sees the request address in the same cycle, then a held copy
      mem_addr          = go_mem ? cpu.cpu_mem_addr  : maddr_q;
      mem_wdata         = go_mem ? cpu.cpu_mem_wdata : mwdata_q;
      mem_wstrb         = go_mem ? cpu.cpu_mem_wstrb : 4'h0;
   end

   // ---------------- MMIO read mux ----------------
   always_comb begin
      status            = '0;
      status[0]         = tx_full;
      status[1]         = tx_empty;
      status[2]         = rx_valid;
      status[3 +: AW+1] = tx_occ;
      mmio_rd           = '0;
      if (is_mmio) begin
         case (off)
            2'd1:    if (is_rd && rx_valid) mmio_rd = rx_data;
            2'd2:    mmio_rd = status;
            default: mmio_rd = '0;
         endcase
      end
   end

   // ---------------- response / held BRAM request ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         err_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         if (go_mem) begin
            maddr_q  <= cpu.cpu_mem_addr;
            mwdata_q <= cpu.cpu_mem_wdata;
            err_q    <= 1'b0;
         end
         if (state == MWAIT) rdata_q <= mem_rdata;
         if (go_resp) begin
            rdata_q <= mmio_rd;          // zero for unmapped
            err_q   <= !is_mmio;
         end
      end
   end

   // ---------------- TX FIFO ----------------
   // pointers carry one extra wrap bit so full and empty differ
   always_comb begin
      tx_occ        = wr_ptr - rd_ptr;
      tx_full       = tx_occ == (AW+1)'(TX_DEPTH);
      tx_empty      = tx_occ == '0;
      link_tx_valid = !tx_empty;
      link_tx_data  = tx_mem[rd_ptr[AW-1:0]];
      tx_pop        = !tx_empty && link_tx_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (tx_push) wr_ptr <= wr_ptr + 1'b1;
         if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[wr_ptr[AW-1:0]] <= cpu.cpu_mem_wdata;
   end

   // ---------------- RX holding register ----------------
   // pop and load never coincide: a load needs the register empty
   assign link_rx_ready = !rx_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else if (rx_pop) begin
         rx_valid <= 1'b0;
      end else if (link_rx_valid && !rx_valid) begin
         rx_valid <= 1'b1;
         rx_data  <= link_rx_data;
      end
   end
endmodule

// File: tb/tb_picorv32_mem_ctrl.sv
module tb_picorv32_mem_ctrl;
   localparam logic [31:0] MEM_TOP = 32'h0001_0000;
   localparam logic [31:0] MMIO    = 32'h8000_0000;
   localparam int          TX_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   picorv32_mem_ctrl_if cpu_if();
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] link_tx_data, link_rx_data;
   logic        link_tx_valid, link_tx_ready, link_rx_valid, link_rx_ready, bus_err;

   picorv32_mem_ctrl #(.MEM_TOP(MEM_TOP), .MMIO_BASE(MMIO), .TX_DEPTH(TX_DEPTH)) dut (
      .clk(clk), .rst(rst), .cpu(cpu_if),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata),
      .link_tx_data(link_tx_data), .link_tx_valid(link_tx_valid),
      .link_tx_ready(link_tx_ready),
      .link_rx_data(link_rx_data), .link_rx_valid(link_rx_valid),
      .link_rx_ready(link_rx_ready),
      .bus_err(bus_err)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit bram_clr = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- BRAM environment (one clock read latency) ----------------
   logic [31:0] bram [0:16383];
   always @(posedge clk) begin
      if (bram_clr) begin
         for (int i = 0; i < 16384; i++) bram[i] <= 32'h0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= bram[mem_addr[15:2]];
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   // Transaction-level view: a countdown to the response, a word array for
   // memory, a queue for the TX FIFO and a flag/word for the RX register.
   logic [31:0] mm [0:16383];
   logic [31:0] txq [$];
   bit          rxv;
   logic [31:0] rxd;
   int          cd;
   logic [31:0] exp_rd, last_maddr;
   bit          exp_err, exp_isrd;

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  ws;
      bit acc_mem, idle, pop, full0, rxv0, rx_take, rd;
      int occ0;
      for (int i = 0; i < 16384; i++) mm[i] = 32'h0;
      cd = 0; rxv = 0; rxd = 0; exp_rd = 0; exp_err = 0; exp_isrd = 0; last_maddr = 0;
      forever begin
         @(negedge clk);
         a  = cpu_if.cpu_mem_addr;
         wd = cpu_if.cpu_mem_wdata;
         ws = cpu_if.cpu_mem_wstrb;
         acc_mem = (cd == 0) && cpu_if.cpu_mem_valid && !rst && a < MEM_TOP;
         if (chk_en) begin
            chk("ready", cpu_if.cpu_mem_ready, cd == 1);
            if (cd == 1 && exp_isrd) chk("rdata", cpu_if.cpu_mem_rdata, exp_rd);
            chk("bus_err", bus_err, cd == 1 && exp_err);
            chk("tx_valid", link_tx_valid, txq.size() != 0);
            if (txq.size() != 0) chk("tx_data", link_tx_data, txq[0]);
            chk("rx_ready", link_rx_ready, !rxv);
            chk("mem_wstrb", mem_wstrb, acc_mem ? ws : 4'h0);
            chk("mem_addr", mem_addr, acc_mem ? a : last_maddr);
            if (acc_mem) chk("mem_wdata", mem_wdata, wd);
         end
         if (rst) begin
            cd = 0; txq.delete(); rxv = 0; rxd = 0; last_maddr = 0; exp_err = 0;
         end else begin
            idle = cd == 0;
            if (cd > 0) cd--;
            occ0    = txq.size();
            full0   = occ0 == TX_DEPTH;
            rxv0    = rxv;
            pop     = occ0 != 0 && link_tx_ready;
            rx_take = link_rx_valid && !rxv0;
            rd      = ws == 4'h0;
            if (idle && cpu_if.cpu_mem_valid) begin
               if (a < MEM_TOP) begin
                  exp_rd = mm[a[15:2]];
                  for (int b = 0; b < 4; b++) if (ws[b]) mm[a[15:2]][8*b +: 8] = wd[8*b +: 8];
                  last_maddr = a; cd = 2; exp_err = 0; exp_isrd = rd;
               end else if (a[31:4] == 28'h800_0000) begin
                  exp_err = 0; exp_isrd = rd; exp_rd = 0; cd = 1;
                  case (a[3:2])
                     2'd0: if (!rd) begin
                              if (full0) cd = 0;      // stalled, retried next cycle
                              else txq.push_back(wd);
                           end
                     2'd1: if (rd && rxv0) begin exp_rd = rxd; rxv = 0; end
                     2'd2: exp_rd = 32'((occ0 << 3) | (int'(rxv0) << 2) |
                                        (int'(occ0 == 0) << 1) | int'(full0));
                     default: exp_rd = 0;
                  endcase
               end else begin
                  exp_rd = 0; exp_err = 1; exp_isrd = 1; cd = 1;
               end
            end
            if (pop) void'(txq.pop_front());
            if (rx_take) begin rxv = 1; rxd = link_rx_data; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int lat, output bit err, output int wcnt);
      bit got;
      got = 0; lat = -1; err = 0; wcnt = 0; rd = 0;
      @(posedge clk); #1;
      cpu_if.cpu_mem_valid = 1'b1;
      cpu_if.cpu_mem_instr = 1'($urandom);
      cpu_if.cpu_mem_addr  = a;
      cpu_if.cpu_mem_wdata = wd;
      cpu_if.cpu_mem_wstrb = ws;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk); #2;
         if (mem_wstrb != 4'h0) wcnt++;
         if (cpu_if.cpu_mem_ready) begin
            got = 1; lat = i; rd = cpu_if.cpu_mem_rdata; err = bus_err;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout addr %h: no ready within 60 cycles, expected a completion", a);
      end
      @(posedge clk); #1;
      cpu_if.cpu_mem_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] r, a;
      logic [31:0] got [$];
      int lat, wc, k;
      bit e, done;
      cpu_if.cpu_mem_valid = 0; cpu_if.cpu_mem_instr = 0; cpu_if.cpu_mem_addr = 0;
      cpu_if.cpu_mem_wdata = 0; cpu_if.cpu_mem_wstrb = 0;
      link_tx_ready = 0; link_rx_valid = 0; link_rx_data = 0;
      done = 0;

      // reset state
      @(posedge clk); #1; chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst ready", cpu_if.cpu_mem_ready, 1'b0);
      chk("rst rdata", cpu_if.cpu_mem_rdata, 32'h0);
      chk("rst bus_err", bus_err, 1'b0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst tx_valid", link_tx_valid, 1'b0);
      chk("rst rx_ready", link_rx_ready, 1'b1);
      @(posedge clk); #1; rst = 0; bram_clr = 0;

      txn(MMIO + 32'h8, 0, 4'h0, r, lat, e, wc);
      chk("status reset", r, 32'h2); chk("status lat", lat, 1);

      // RAM write/read
      txn(32'h8004, 32'hDEADBEEF, 4'hF, r, lat, e, wc);
      chk("ram wr lat", lat, 2); chk("ram wr wstrb cycles", wc, 1);
      txn(32'h8004, 32'h0, 4'h0, r, lat, e, wc);
      chk("ram rd lat", lat, 2); chk("ram rd data", r, 32'hDEADBEEF); chk("ram rd wstrb", wc, 0);

      // byte strobe
      txn(32'h8008, 32'h11223344, 4'hF, r, lat, e, wc);
      txn(32'h8008, 32'h000000AA, 4'h1, r, lat, e, wc);
      txn(32'h8008, 32'h0, 4'h0, r, lat, e, wc);
      chk("byte strobe", r, 32'h112233AA);

      // TX FIFO fill, stall, release, drain
      for (int v = 1; v <= 4; v++) begin
         txn(MMIO, 32'(v), 4'hF, r, lat, e, wc);
         chk("tx wr lat", lat, 1);
      end
      txn(MMIO + 32'h8, 0, 4'h0, r, lat, e, wc);
      chk("status full", r, 32'h21);
      fork
         begin
            txn(MMIO, 32'h5, 4'hF, r, lat, e, wc);
            chk("tx stall lat", lat, 4);
         end
         begin
            repeat (3) @(posedge clk);
            #1 link_tx_ready = 1;
            @(negedge clk); #2;
            chk("tx head", link_tx_data, 32'h1);
            @(posedge clk); #1 link_tx_ready = 0;
         end
      join
      link_tx_ready = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #2;
         if (link_tx_valid) got.push_back(link_tx_data);
      end
      link_tx_ready = 0;
      chk("drain count", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk("drain order", got[i], 32'(i + 2));

      // RX path
      @(posedge clk); #1; link_rx_data = 32'h55; link_rx_valid = 1;
      @(posedge clk); @(negedge clk);
      chk("rx loaded", link_rx_ready, 1'b0);
      txn(MMIO + 32'h8, 0, 4'h0, r, lat, e, wc);
      chk("status rx", r, 32'h6);
      link_rx_data = 32'h66;
      txn(MMIO + 32'h4, 0, 4'h0, r, lat, e, wc);
      chk("rx data", r, 32'h55);
      chk("rx reload", link_rx_ready, 1'b0);
      link_rx_valid = 0;
      txn(MMIO + 32'h4, 0, 4'h0, r, lat, e, wc);
      chk("rx next", r, 32'h66);
      txn(MMIO + 32'h4, 0, 4'h0, r, lat, e, wc);
      chk("rx empty", r, 32'h0);

      // unmapped and decode boundaries
      txn(32'h4000_0000, 0, 4'h0, r, lat, e, wc);
      chk("unmap lat", lat, 1); chk("unmap rdata", r, 32'h0);
      chk("unmap err", e, 1'b1); chk("unmap wstrb", wc, 0);
      txn(32'h0001_0000, 32'h77, 4'hF, r, lat, e, wc);
      chk("memtop err", e, 1'b1); chk("memtop wstrb", wc, 0);
      txn(32'h0000_FFFC, 0, 4'h0, r, lat, e, wc);
      chk("memtop-4 lat", lat, 2); chk("memtop-4 err", e, 1'b0);
      txn(32'h8000_0010, 0, 4'h0, r, lat, e, wc);
      chk("past window err", e, 1'b1);
      txn(MMIO + 32'hC, 0, 4'h0, r, lat, e, wc);
      chk("off3 err", e, 1'b0); chk("off3 rdata", r, 32'h0);

      // reset in MWAIT of a write
      @(posedge clk); #1;
      cpu_if.cpu_mem_valid = 1; cpu_if.cpu_mem_addr = 32'h100;
      cpu_if.cpu_mem_wdata = 32'h1234; cpu_if.cpu_mem_wstrb = 4'hF;
      @(posedge clk); #1; rst = 1; cpu_if.cpu_mem_valid = 0;
      @(posedge clk); @(negedge clk);
      chk("midrst ready", cpu_if.cpu_mem_ready, 1'b0);
      chk("midrst mem_addr", mem_addr, 32'h0);
      chk("midrst wstrb", mem_wstrb, 4'h0);
      chk("midrst err", bus_err, 1'b0);
      @(posedge clk); #1; rst = 0;
      txn(32'h8004, 0, 4'h0, r, lat, e, wc);
      chk("post rst lat", lat, 2); chk("post rst data", r, 32'hDEADBEEF);

      // randomized traffic, checked by the model every cycle
      fork
         begin
            while (!done) begin
               @(posedge clk); #1;
               link_tx_ready = 1'($urandom);
               link_rx_valid = ($urandom % 3) == 0;
               link_rx_data  = $urandom;
            end
         end
         begin
            for (int n = 0; n < 400; n++) begin
               k = $urandom_range(0, 9);
               a = 32'h8000 + ($urandom_range(0, 15) << 2);
               if ($urandom_range(0, 7) == 0) a = 32'h0000_FFFC;
               case (k)
                  0, 1: txn(a, $urandom, 4'($urandom_range(1, 15)), r, lat, e, wc);
                  2, 3: txn(a, 0, 4'h0, r, lat, e, wc);
                  4:    txn(MMIO, $urandom, 4'($urandom_range(1, 15)), r, lat, e, wc);
                  5:    txn(MMIO + 32'h4, 0, 4'h0, r, lat, e, wc);
                  6:    txn(MMIO + 32'h8, 0, 4'h0, r, lat, e, wc);
                  7:    txn(MMIO + 32'hC, $urandom, 4'($urandom_range(0, 15)), r, lat, e, wc);
                  8: begin
                     case ($urandom_range(0, 3))
                        0: a = 32'h0001_0000;
                        1: a = 32'h4000_0000;
                        2: a = 32'h8000_0010;
                        default: a = 32'hFFFF_FFF0;
                     endcase
                     txn(a, $urandom, 4'($urandom_range(0, 15)), r, lat, e, wc);
                  end
                  default: txn(MMIO + ($urandom_range(1, 2) << 2), $urandom,
                               4'($urandom_range(1, 15)), r, lat, e, wc);
               endcase
            end
            done = 1;
         end
      join

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
